// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types and constants for the branch redirect controller.
// The state enum is shared so other blocks can decode redirect status consistently.
package branch_redirect_ctrl_pkg;

    typedef enum logic [1:0] {
        RC_IDLE     = 2'd0,
        RC_REDIRECT = 2'd1,
        RC_FLUSH    = 2'd2
    } redir_state_t;

    localparam int         RC_FLUSH_DEPTH_DEF = 2;
    localparam logic [1:0] INST_ALIGN_MASK    = 2'b11;

endpackage

// File: rtl/branch_redirect_ctrl_perf_counters.sv
// Branch and taken-redirect performance counters for the redirect controller.
// Both counters wrap naturally and share one synchronous clear.
module br_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             br_inc_i,
    input  logic             taken_inc_i,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] taken_cnt_o
);

    logic [CNT_W-1:0] br_cnt_q;
    logic [CNT_W-1:0] br_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q;
    logic [CNT_W-1:0] taken_cnt_d;

    always_comb begin
        br_cnt_d    = br_cnt_q;
        taken_cnt_d = taken_cnt_q;
        if (br_inc_i) begin
            br_cnt_d = br_cnt_q + CNT_W'(1);
        end
        if (taken_inc_i) begin
            taken_cnt_d = taken_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
        end else begin
            br_cnt_q    <= br_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign br_cnt_o    = br_cnt_q;
    assign taken_cnt_o = taken_cnt_q;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Post-execute branch redirect sequencer: registered redirect handshake to fetch,
// upstream stall/kill, wrong-path flush and misaligned-target exception pulse.
//
// state       | meaning
// ------------+------------------------------------------------------------
// RC_IDLE     | accepting resolved branches from execute
// RC_REDIRECT | redirect presented to fetch, upstream stalled and killed
// RC_FLUSH    | redirect accepted, squashing remaining wrong-path slots
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int FLUSH_DEPTH = RC_FLUSH_DEPTH_DEF,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             br_valid,
    input  logic             br_taken,
    input  logic [XLEN-1:0]  br_target,
    output logic             redir_valid,
    output logic [XLEN-1:0]  redir_pc,
    input  logic             redir_ready,
    output logic             stall_o,
    output logic             kill_o,
    output logic             misalign_o,
    output logic [XLEN-1:0]  misalign_tval,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_DEPTH);

    redir_state_t    state_q;
    redir_state_t    state_d;
    logic [2:0]      flush_cnt_q;
    logic [2:0]      flush_cnt_d;
    logic [XLEN-1:0] redir_pc_q;
    logic [XLEN-1:0] redir_pc_d;
    logic            redir_valid_q;
    logic            redir_valid_d;
    logic            stall_q;
    logic            stall_d;
    logic            kill_q;
    logic            kill_d;
    logic            misalign_q;
    logic            misalign_d;
    logic [XLEN-1:0] tval_q;
    logic [XLEN-1:0] tval_d;
    logic            br_inc;
    logic            taken_inc;
    logic            target_misaligned;
    logic            handshake;

    assign target_misaligned = (br_target[1:0] & INST_ALIGN_MASK) != 2'b00;
    assign handshake         = redir_valid_q && redir_ready;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        redir_pc_d  = redir_pc_q;
        misalign_d  = 1'b0;
        tval_d      = '0;
        br_inc      = 1'b0;
        taken_inc   = 1'b0;

        case (state_q)
            RC_IDLE: begin
                redir_pc_d = '0;
                if (br_valid) begin
                    br_inc = 1'b1;
                    if (br_taken) begin
                        if (target_misaligned) begin
                            misalign_d = 1'b1;
                            tval_d     = br_target;
                        end else begin
                            state_d    = RC_REDIRECT;
                            redir_pc_d = br_target;
                            taken_inc  = 1'b1;
                        end
                    end
                end
            end
            // Branches arriving here are wrong-path or stalled; they are dropped.
            RC_REDIRECT: begin
                if (handshake) begin
                    redir_pc_d = '0;
                    if (FLUSH_DEPTH == 0) begin
                        state_d = RC_IDLE;
                    end else begin
                        state_d     = RC_FLUSH;
                        flush_cnt_d = FLUSH_INIT;
                    end
                end
            end
            RC_FLUSH: begin
                if (flush_cnt_q <= 3'd1) begin
                    state_d     = RC_IDLE;
                    flush_cnt_d = 3'd0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end
            end
            default: begin
                state_d     = RC_IDLE;
                flush_cnt_d = 3'd0;
                redir_pc_d  = '0;
            end
        endcase

        redir_valid_d = (state_d == RC_REDIRECT);
        stall_d       = (state_d == RC_REDIRECT);
        kill_d        = (state_d != RC_IDLE) || misalign_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= RC_IDLE;
            flush_cnt_q   <= 3'd0;
            redir_pc_q    <= '0;
            redir_valid_q <= 1'b0;
            stall_q       <= 1'b0;
            kill_q        <= 1'b0;
            misalign_q    <= 1'b0;
            tval_q        <= '0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            redir_pc_q    <= redir_pc_d;
            redir_valid_q <= redir_valid_d;
            stall_q       <= stall_d;
            kill_q        <= kill_d;
            misalign_q    <= misalign_d;
            tval_q        <= tval_d;
        end
    end

    br_perf_counters #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk_i       (i_clk),
        .clr_i       (i_rst),
        .br_inc_i    (br_inc),
        .taken_inc_i (taken_inc),
        .br_cnt_o    (br_cnt),
        .taken_cnt_o (taken_cnt)
    );

    assign redir_valid   = redir_valid_q;
    assign redir_pc      = redir_pc_q;
    assign stall_o       = stall_q;
    assign kill_o        = kill_q;
    assign misalign_o    = misalign_q;
    assign misalign_tval = tval_q;

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
Sequences the control-flow redirect that follows branch resolution in execute. It takes the branch unit's taken/target result, presents a registered redirect to fetch with a valid/ready handshake, and holds upstream stages stalled until fetch accepts. It then squashes a fixed number of wrong-path slots and raises a misaligned-target exception instead of redirecting when required. It also keeps branch/taken performance counters.

Parameters:
XLEN, 32, datapath/PC width
FLUSH_DEPTH, 2, wrong-path slots squashed after redirect acceptance (0..7)
CNT_W, 32, width of performance counters

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
br_valid  in  1  branch instruction resolved in execute this cycle (branch_control != NOP)
br_taken  in  1  branch unit pc_update_control
br_target  in  XLEN  branch unit pc_update_val
redir_valid  out  1  redirect request to fetch
redir_pc  out  XLEN  redirect target
redir_ready  in  1  fetch accepts redirect
stall_o  out  1  hold execute and upstream stages
kill_o  out  1  squash instruction in decode/execute slot this cycle
misalign_o  out  1  one-cycle pulse: taken target not 4-byte aligned
misalign_tval  out  XLEN  offending target, valid with misalign_o
br_cnt  out  CNT_W  resolved branches accepted in IDLE
taken_cnt  out  CNT_W  redirects issued

Behaviour:
- Reset (i_rst=1 at posedge): state IDLE; all outputs 0; counters 0; any pending redirect or flush dropped. Applies mid-REDIRECT/FLUSH as well.
- All outputs are registered.
- States: IDLE, REDIRECT, FLUSH.
- IDLE, br_valid=0: stay; outputs 0.
- IDLE, br_valid=1, br_taken=0: stay; br_cnt+1.
- IDLE, br_valid=1, br_taken=1, br_target[1:0]!=0: stay, no redirect.
  - Next cycle: misalign_o=1, misalign_tval=br_target, kill_o=1 for one cycle.
  - br_cnt+1; taken_cnt unchanged.
- IDLE, br_valid=1, br_taken=1, aligned: capture redir_pc=br_target; go REDIRECT; br_cnt+1, taken_cnt+1.
  - Latency: redir_valid, stall_o and kill_o assert the cycle after br_valid.
- REDIRECT: redir_valid=1, stall_o=1, kill_o=1.
  - redir_pc is held stable while redir_valid=1 and redir_ready=0. No timeout.
  - Handshake completes on a cycle with redir_valid=1 and redir_ready=1.
    - If FLUSH_DEPTH=0: go IDLE.
    - Otherwise: go FLUSH with flush counter = FLUSH_DEPTH.
  - The next cycle has redir_valid=0 and stall_o=0.
- FLUSH: kill_o=1, stall_o=0, redir_valid=0.
  - Counter decrements each cycle; when counter==1, go IDLE.
  - kill_o is therefore high for exactly FLUSH_DEPTH cycles after acceptance.
- br_valid in REDIRECT or FLUSH: ignored as a wrong-path or stalled instruction; no counter change, no state change.
- Counters wrap modulo 2^CNT_W. No saturation.
- Flush counter width: 3 bits.

Decomposition:
- Shared package (processor package) holds:
  - typedef enum logic [1:0] {RC_IDLE, RC_REDIRECT, RC_FLUSH} redir_state_t
  - constants RC_FLUSH_DEPTH_DEF=2 and INST_ALIGN_MASK=2'b11
- One sub-module: br_perf_counters (two CNT_W counters with increment enables and synchronous active-high clear).
- FSM and handshake stay in branch_redirect_ctrl.

Test Plan:
- Not-taken: br_valid=1, br_taken=0 for 3 cycles -> br_cnt=3, taken_cnt=0, redir_valid/kill_o/stall_o never 1.
- Taken with ready: br_target=0x0000_0100, redir_ready tied 1 -> next cycle redir_valid=1, redir_pc=0x100, stall_o=1; then kill_o=1 for 2 cycles; then IDLE; taken_cnt=1.
- Backpressure: taken to 0x200, redir_ready=0 for 4 cycles, then 1 -> redir_valid held 5 cycles with redir_pc=0x200 stable; stall_o high throughout; kill_o high 5+2 cycles total.
- Misaligned: taken, br_target=0x0000_0102 -> next cycle misalign_o=1 (single cycle), misalign_tval=0x102, kill_o=1, redir_valid=0; taken_cnt unchanged; br_cnt+1.
- Branch while busy: second br_valid/br_taken to 0x300 during REDIRECT and FLUSH -> ignored; redir_pc stays at first target; br_cnt and taken_cnt each +1 only.
- Reset mid-operation: i_rst=1 during REDIRECT with redir_ready=0 -> next cycle all outputs 0, counters 0; a later taken branch redirects normally.
